// File: rtl/key_event_gen.sv
// Key event generator: turns debounced key levels into PRESS/RELEASE/LONG/REPEAT events on a valid/ready output.
// Define KEY_EVENT_GEN_REPEAT_EN to enable auto-repeat while a key stays long-held.
module key_event_gen #(
    parameter int p_KEYS         = 4,
    parameter int p_IDX_WIDTH    = 2,
    parameter int p_TICK_WIDTH   = 4,
    parameter int p_LONG_TICKS   = 8,
    parameter int p_REPEAT_TICKS = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [p_KEYS-1:0]      iv_keys,
    input  logic                   i_ready,
    output logic                   o_valid,
    output logic [p_IDX_WIDTH-1:0] ov_key,
    output logic [1:0]             ov_type,
    output logic                   o_overflow
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HELD     = 2'd1,
        ST_LONGHELD = 2'd2
    } state_t;

    localparam logic [1:0] EV_PRESS   = 2'd0;
    localparam logic [1:0] EV_RELEASE = 2'd1;
    localparam logic [1:0] EV_LONG    = 2'd2;
    localparam logic [1:0] EV_REPEAT  = 2'd3;

    localparam logic [7:0] LONG_LIM   = 8'(p_LONG_TICKS);
    localparam logic [7:0] REPEAT_LIM = 8'(p_REPEAT_TICKS);

    generate
        if (p_KEYS < 1 || p_KEYS > 16 || (1 << p_IDX_WIDTH) < p_KEYS ||
            p_LONG_TICKS < 1 || p_LONG_TICKS > 255 ||
            p_REPEAT_TICKS < 1 || p_REPEAT_TICKS > 255 || p_TICK_WIDTH < 1) begin : g_param_check
            $error("key_event_gen: illegal parameter combination");
        end
    endgenerate

    logic [p_KEYS-1:0]       rv_keys_q, rv_keys_d;
    logic [p_TICK_WIDTH-1:0] presc_q, presc_d;
    logic                    tick;

    state_t                  state_q [p_KEYS];
    state_t                  state_d [p_KEYS];
    logic [7:0]              cnt_q   [p_KEYS];
    logic [7:0]              cnt_d   [p_KEYS];
    logic [p_KEYS-1:0]       emit;
    logic [1:0]              emit_type [p_KEYS];

    logic [p_KEYS-1:0]       pend_q, pend_d;
    logic [1:0]              ptype_q [p_KEYS];
    logic [1:0]              ptype_d [p_KEYS];

    logic                    valid_q, valid_d;
    logic [p_IDX_WIDTH-1:0]  key_q, key_d;
    logic [1:0]              type_q, type_d;
    logic                    ovf_q, ovf_d;

    logic                    load;
    logic                    any_pend;
    logic [p_IDX_WIDTH-1:0]  sel;
    logic [1:0]              sel_type;
    logic [p_KEYS-1:0]       sel_onehot;
    logic [p_KEYS-1:0]       drain;

    assign tick = &presc_q;

    always_comb begin
        rv_keys_d = iv_keys;
        presc_d   = presc_q + 1'b1;
    end

    // Per-key FSMs; a release always wins over a tick in the same cycle.
    always_comb begin
        for (int k = 0; k < p_KEYS; k++) begin
            state_d[k]   = state_q[k];
            cnt_d[k]     = cnt_q[k];
            emit[k]      = 1'b0;
            emit_type[k] = EV_PRESS;
            case (state_q[k])
                ST_IDLE: begin
                    if (rv_keys_q[k]) begin
                        emit[k]    = 1'b1;
                        cnt_d[k]   = 8'd0;
                        state_d[k] = ST_HELD;
                    end
                end
                ST_HELD: begin
                    if (!rv_keys_q[k]) begin
                        emit[k]      = 1'b1;
                        emit_type[k] = EV_RELEASE;
                        state_d[k]   = ST_IDLE;
                    end else if (tick) begin
                        if (cnt_q[k] + 8'd1 == LONG_LIM) begin
                            emit[k]      = 1'b1;
                            emit_type[k] = EV_LONG;
                            cnt_d[k]     = 8'd0;
                            state_d[k]   = ST_LONGHELD;
                        end else begin
                            cnt_d[k] = cnt_q[k] + 8'd1;
                        end
                    end
                end
                ST_LONGHELD: begin
`ifdef KEY_EVENT_GEN_REPEAT_EN
                    if (!rv_keys_q[k]) begin
                        emit[k]      = 1'b1;
                        emit_type[k] = EV_RELEASE;
                        state_d[k]   = ST_IDLE;
                    end else if (tick) begin
                        if (cnt_q[k] + 8'd1 == REPEAT_LIM) begin
                            emit[k]      = 1'b1;
                            emit_type[k] = EV_REPEAT;
                            cnt_d[k]     = 8'd0;
                        end else begin
                            cnt_d[k] = cnt_q[k] + 8'd1;
                        end
                    end
`else
                    if (!rv_keys_q[k]) begin
                        emit[k]      = 1'b1;
                        emit_type[k] = EV_RELEASE;
                        state_d[k]   = ST_IDLE;
                    end
`endif
                end
                default: state_d[k] = ST_IDLE;
            endcase
        end
    end

    // Output register picks the lowest-index pending slot whenever it is free or being accepted.
    always_comb begin
        any_pend   = |pend_q;
        sel        = '0;
        sel_type   = EV_PRESS;
        sel_onehot = '0;
        for (int i = p_KEYS - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                sel           = p_IDX_WIDTH'(i);
                sel_type      = ptype_q[i];
                sel_onehot    = '0;
                sel_onehot[i] = 1'b1;
            end
        end
        load    = !valid_q || i_ready;
        drain   = load ? sel_onehot : '0;
        valid_d = valid_q;
        key_d   = key_q;
        type_d  = type_q;
        if (load) begin
            valid_d = any_pend;
            if (any_pend) begin
                key_d  = sel;
                type_d = sel_type;
            end
        end
    end

    // A fresh event always lands in its slot; it only counts as overflow if the old one was not drained.
    always_comb begin
        ovf_d = ovf_q;
        for (int k = 0; k < p_KEYS; k++) begin
            pend_d[k]  = pend_q[k] & ~drain[k];
            ptype_d[k] = ptype_q[k];
            if (emit[k]) begin
                if (pend_q[k] && !drain[k]) begin
                    ovf_d = 1'b1;
                end
                pend_d[k]  = 1'b1;
                ptype_d[k] = emit_type[k];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rv_keys_q <= '0;
            presc_q   <= '0;
            pend_q    <= '0;
            valid_q   <= 1'b0;
            key_q     <= '0;
            type_q    <= 2'd0;
            ovf_q     <= 1'b0;
            for (int k = 0; k < p_KEYS; k++) begin
                state_q[k] <= ST_IDLE;
                cnt_q[k]   <= 8'd0;
                ptype_q[k] <= 2'd0;
            end
        end else begin
            rv_keys_q <= rv_keys_d;
            presc_q   <= presc_d;
            pend_q    <= pend_d;
            valid_q   <= valid_d;
            key_q     <= key_d;
            type_q    <= type_d;
            ovf_q     <= ovf_d;
            for (int k = 0; k < p_KEYS; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
                ptype_q[k] <= ptype_d[k];
            end
        end
    end

    assign o_valid    = valid_q;
    assign ov_key     = key_q;
    assign ov_type    = type_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_key_event_gen.sv
// Self-checking bench for key_event_gen: directed scenarios plus random key/ready traffic
// compared against a tick-counting event model.
module tb_key_event_gen;

   localparam int KEYS     = 4;
   localparam int TICKW    = 2;
   localparam int LONGT    = 3;
   localparam int REPT     = 2;
   localparam int TICKPER  = 1 << TICKW;
`ifdef KEY_EVENT_GEN_REPEAT_EN
   localparam bit REP_EN   = 1'b1;
`else
   localparam bit REP_EN   = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rstN;
   logic [3:0] keysIn;
   logic       readyIn;
   logic       validOut;
   logic [1:0] keyOut;
   logic [1:0] typeOut;
   logic       ovfOut;

   int checks = 0;
   int errors = 0;

   // Reference model state: levels seen by the key logic, hold status and ticks since press
   int         mCyc;
   logic [3:0] mRv;
   logic [3:0] mHeld;
   int         mTicks [4];
   logic [3:0] mPend;
   int         mPtype [4];
   bit         mValid;
   int         mKey;
   int         mType;
   bit         mOvf;

   int cntType [4];

   key_event_gen #(
      .p_KEYS(KEYS),
      .p_IDX_WIDTH(2),
      .p_TICK_WIDTH(TICKW),
      .p_LONG_TICKS(LONGT),
      .p_REPEAT_TICKS(REPT)
   ) dut (
      .i_clk(clk),
      .i_rst_n(rstN),
      .iv_keys(keysIn),
      .i_ready(readyIn),
      .o_valid(validOut),
      .ov_key(keyOut),
      .ov_type(typeOut),
      .o_overflow(ovfOut)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %0d expected %0d", tag, $time, act, exp);
      end
   endtask

   task automatic modelReset();
      mCyc   = 0;
      mRv    = '0;
      mHeld  = '0;
      mPend  = '0;
      mValid = 1'b0;
      mKey   = 0;
      mType  = 0;
      mOvf   = 1'b0;
      for (int k = 0; k < 4; k++) begin
         mTicks[k] = 0;
         mPtype[k] = 0;
      end
   endtask

   // One clock edge of the model, using the inputs that were stable before the edge
   task automatic modelStep(input logic [3:0] keys, input logic rdy);
      bit tick;
      bit ev [4];
      int evType [4];
      bit drained [4];
      bit found;
      tick = ((mCyc % TICKPER) == TICKPER - 1);
      for (int k = 0; k < 4; k++) begin
         ev[k] = 1'b0;
         evType[k] = 0;
         drained[k] = 1'b0;
         if (!mHeld[k] && mRv[k]) begin
            ev[k] = 1'b1; evType[k] = 0; mHeld[k] = 1'b1; mTicks[k] = 0;
         end else if (mHeld[k] && !mRv[k]) begin
            ev[k] = 1'b1; evType[k] = 1; mHeld[k] = 1'b0;
         end else if (mHeld[k] && tick) begin
            mTicks[k]++;
            if (mTicks[k] == LONGT) begin
               ev[k] = 1'b1; evType[k] = 2;
            end else if (REP_EN && mTicks[k] > LONGT && ((mTicks[k] - LONGT) % REPT) == 0) begin
               ev[k] = 1'b1; evType[k] = 3;
            end
         end
      end
      if (!mValid || rdy) begin
         found = 1'b0;
         for (int k = 0; k < 4; k++) begin
            if (!found && mPend[k]) begin
               found = 1'b1; mKey = k; mType = mPtype[k]; drained[k] = 1'b1;
            end
         end
         mValid = found;
      end
      for (int k = 0; k < 4; k++) begin
         if (ev[k]) begin
            if (mPend[k] && !drained[k]) mOvf = 1'b1;
            mPend[k] = 1'b1;
            mPtype[k] = evType[k];
         end else if (drained[k]) begin
            mPend[k] = 1'b0;
         end
      end
      mRv = keys;
      mCyc++;
   endtask

   task automatic compareAll();
      checkOutput("valid", validOut, mValid);
      if (mValid) begin
         checkOutput("key", keyOut, mKey);
         checkOutput("type", typeOut, mType);
      end
      checkOutput("overflow", ovfOut, mOvf);
   endtask

   task automatic applyStimulus(input logic [3:0] keys, input logic rdy);
      @(negedge clk);
      compareAll();
      keysIn  = keys;
      readyIn = rdy;
      if (validOut && rdy) cntType[typeOut]++;
      @(posedge clk);
      modelStep(keys, rdy);
   endtask

   task automatic clearCounts();
      for (int t = 0; t < 4; t++) cntType[t] = 0;
   endtask

   task automatic pulseReset();
      @(negedge clk);
      compareAll();
      rstN = 1'b0;
      #1;
      checkOutput("rst_valid", validOut, 0);
      checkOutput("rst_key", keyOut, 0);
      checkOutput("rst_type", typeOut, 0);
      checkOutput("rst_overflow", ovfOut, 0);
      modelReset();
      @(negedge clk);
      rstN = 1'b1;
      @(posedge clk);
      modelStep(keysIn, readyIn);
   endtask

   initial begin
      logic [3:0] rk;
      rstN    = 1'b0;
      keysIn  = 4'b1111;
      readyIn = 1'b1;
      modelReset();
      clearCounts();
      #2;
      checkOutput("init_valid", validOut, 0);
      checkOutput("init_key", keyOut, 0);
      checkOutput("init_type", typeOut, 0);
      checkOutput("init_overflow", ovfOut, 0);
      @(negedge clk);
      @(negedge clk);
      rstN = 1'b1;
      @(posedge clk);
      modelStep(keysIn, readyIn);

      // All keys held through reset: four presses, then release them
      repeat (6) applyStimulus(4'b1111, 1'b1);
      repeat (14) applyStimulus(4'b0000, 1'b1);
      checkOutput("reset_press_count", cntType[0], 4);
      checkOutput("reset_release_count", cntType[1], 4);

      // Short tap on key 2
      clearCounts();
      repeat (3) applyStimulus(4'b0100, 1'b1);
      repeat (10) applyStimulus(4'b0000, 1'b1);
      checkOutput("tap_press", cntType[0], 1);
      checkOutput("tap_release", cntType[1], 1);
      checkOutput("tap_long", cntType[2], 0);
      checkOutput("tap_overflow", ovfOut, 0);

      // Long hold on key 1 for 40 clocks
      clearCounts();
      repeat (40) applyStimulus(4'b0010, 1'b1);
      repeat (10) applyStimulus(4'b0000, 1'b1);
      checkOutput("hold_press", cntType[0], 1);
      checkOutput("hold_long", cntType[2], 1);
      checkOutput("hold_repeat", cntType[3], REP_EN ? 3 : 0);
      checkOutput("hold_release", cntType[1], 1);

      // Backpressure: press/release/press while the output is stalled
      repeat (3) applyStimulus(4'b0001, 1'b0);
      repeat (3) applyStimulus(4'b0000, 1'b0);
      repeat (3) applyStimulus(4'b0001, 1'b0);
      @(negedge clk);
      checkOutput("bp_overflow", ovfOut, 1);
      checkOutput("bp_valid", validOut, 1);
      checkOutput("bp_type", typeOut, 0);
      checkOutput("bp_key", keyOut, 0);
      @(posedge clk);
      modelStep(keysIn, readyIn);
      repeat (4) applyStimulus(4'b0001, 1'b1);
      repeat (10) applyStimulus(4'b0000, 1'b1);

      // Mid-operation reset while key 3 is long-held
      repeat (20) applyStimulus(4'b1000, 1'b1);
      pulseReset();
      clearCounts();
      repeat (20) applyStimulus(4'b1000, 1'b1);
      checkOutput("postrst_press", cntType[0], 1);
      checkOutput("postrst_long", cntType[2], 1);
      repeat (10) applyStimulus(4'b0000, 1'b1);

      // Random key activity with random backpressure
      rk = 4'b0000;
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(15) == 0) rk[b] = ~rk[b];
         end
         applyStimulus(rk, $urandom_range(3) != 0);
      end
      repeat (20) applyStimulus(4'b0000, 1'b1);
      @(negedge clk);
      compareAll();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
